div_sequencer: RTL

Multi-cycle sequencer for MIPS DIV/DIVU. It runs restoring division by time-sharing one `sub_func` instance for the per-bit trial subtraction, and delivers quotient (LO) and remainder (HI). It sits beside the single-cycle ALU and is started by the control unit. The control unit holds the pipeline stall while `busy` is high.

---
 rtl/div_sequencer_if.sv | 24 ++
 rtl/div_sequencer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Divider request/result bundle between the control unit and div_sequencer.
interface div_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU sharing one 32-bit subtractor.
module sub_func (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sub_circ,
   output logic        borrow
);
   assign {borrow, sub_circ} = {1'b0, a} - {1'b0, b};
endmodule

module div_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic           clock,
   input  logic           reset_n,
   div_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_ITER  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] qr_q, qr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             nq_q, nq_d;
   logic             nr_q, nr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] diff;
   logic             m;
   logic             borrow;
   logic             ok;

   // Shift the top quotient bit into the partial remainder; m is the bit shifted out.
   assign m  = r_q[WIDTH-1];
   assign t  = {r_q[WIDTH-2:0], qr_q[WIDTH-1]};
   assign ok = m | ~borrow;

   sub_func u_sub (
      .a       (t),
      .b       (b_q),
      .sub_circ(diff),
      .borrow  (borrow)
   );

   always_comb begin
      state_d = state_q;
      sgn_d   = sgn_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      qr_d    = qr_q;
      cnt_d   = cnt_q;
      nq_d    = nq_q;
      nr_d    = nr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               a_d     = bus.dividend;
               b_d     = bus.divisor;
               sgn_d   = bus.is_signed;
               dbz_d   = 1'b0;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            nq_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            nr_d  = sgn_q & a_q[WIDTH-1];
            r_d   = '0;
            qr_d  = (sgn_q & a_q[WIDTH-1]) ? -a_q : a_q;
            b_d   = (sgn_q & b_q[WIDTH-1]) ? -b_q : b_q;
            cnt_d = CW'(WIDTH - 1);
            if (b_q == '0) begin
               quot_d  = '1;
               rem_d   = a_q;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            r_d   = ok ? diff : t;
            qr_d  = {qr_q[WIDTH-2:0], ok};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            quot_d  = nq_q ? -qr_q : qr_q;
            rem_d   = nr_q ? -r_q : r_q;
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         sgn_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         qr_q    <= '0;
         cnt_q   <= '0;
         nq_q    <= 1'b0;
         nr_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sgn_q   <= sgn_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         qr_q    <= qr_d;
         cnt_q   <= cnt_d;
         nq_q    <= nq_d;
         nr_q    <= nr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule
